// File: rtl/sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// sim_run_ctrl
//
// Run sequencer for the simulation top level. A run is requested with i_start.
// The block then releases N DUT reset domains one after another, counts RUN
// cycles, and stops the run on the first of: DUT error, DUT done, global
// timeout, or heartbeat watchdog expiry. The verdict is latched in DONE so the
// bench can poll it and end the simulation.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_IDLE  | after reset; all DUT resets held, waiting for i_start
//   S_RESET | reset counter running; domains released in index order
//   S_RUN   | all domains out of reset; cycle and watchdog counters active
//   S_DONE  | verdict latched; i_start begins a fresh run
//
// Ports:
//   i_clk           clock, all logic on the rising edge
//   i_reset         asynchronous active-high reset, returns to S_IDLE
//   i_start         begin a run (sampled in S_IDLE and S_DONE)
//   i_dut_done      DUT reports completion (sampled in S_RUN)
//   i_dut_error     DUT reports failure (sampled in S_RUN, beats i_dut_done)
//   i_heartbeat     watchdog kick (sampled in S_RUN)
//   o_dut_reset     per-domain active-high reset to the DUT
//   o_running       high while in S_RUN
//   o_done          high while in S_DONE
//   o_status        00 none, 01 pass, 10 error, 11 timeout
//   o_wdog_expired  timeout verdict came from the watchdog
//   o_cycle_count   RUN cycles elapsed, frozen in S_DONE, saturating
// -----------------------------------------------------------------------------
module sim_run_ctrl #(
  parameter int NUM_DOMAINS    = 2,
  parameter int RST_CYCLES     = 2,
  parameter int STAGGER        = 1,
  parameter int TIMEOUT_CYCLES = 10,
  parameter int WDOG_CYCLES    = 0,
  parameter int CNT_W          = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_dut_done,
  input  logic                   i_dut_error,
  input  logic                   i_heartbeat,
  output logic [NUM_DOMAINS-1:0] o_dut_reset,
  output logic                   o_running,
  output logic                   o_done,
  output logic [1:0]             o_status,
  output logic                   o_wdog_expired,
  output logic [CNT_W-1:0]       o_cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  // Terminal-count values: the run stops when the counter already holds the
  // last legal value, so the compare is against N-1 rather than N.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'((WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1);
  localparam logic WD_EN = (WDOG_CYCLES != 0);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_rst_cnt;
  logic [CNT_W-1:0]       r_wdog_cnt;
  logic [CNT_W-1:0]       r_cycle_count;
  logic [NUM_DOMAINS-1:0] r_dut_reset;
  logic                   r_running;
  logic                   r_done;
  logic [1:0]             r_status;
  logic                   r_wdog_expired;

  logic [CNT_W-1:0]       w_rst_next;
  logic [NUM_DOMAINS-1:0] w_rst_release;
  logic                   w_timeout;
  logic                   w_wdog_trip;
  logic                   w_cycle_sat;
  logic                   w_wdog_sat;

  // Number of RESET-state edges domain idx stays in reset, counted from the
  // start edge.
  function automatic logic [CNT_W-1:0] hold_cycles(input int idx);
    return CNT_W'(RST_CYCLES + idx * STAGGER);
  endfunction

  // A domain is released at the edge where the incremented reset count
  // reaches its hold length; the count only rises, so released bits stay low.
  always_comb begin
    w_rst_next    = r_rst_cnt + CNT_W'(1);
    w_rst_release = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      w_rst_release[i] = (w_rst_next >= hold_cycles(i));
    end
  end

  assign w_timeout   = (r_cycle_count == TO_LAST);
  assign w_wdog_trip = WD_EN && !i_heartbeat && (r_wdog_cnt == WD_LAST);
  assign w_cycle_sat = &r_cycle_count;
  assign w_wdog_sat  = &r_wdog_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_rst_cnt      <= '0;
      r_wdog_cnt     <= '0;
      r_cycle_count  <= '0;
      r_dut_reset    <= '1;
      r_running      <= 1'b0;
      r_done         <= 1'b0;
      r_status       <= ST_NONE;
      r_wdog_expired <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dut_reset <= '1;
          if (i_start) begin
            r_state   <= S_RESET;
            r_rst_cnt <= '0;
          end
        end

        S_RESET: begin
          r_rst_cnt   <= w_rst_next;
          r_dut_reset <= ~w_rst_release;
          // The highest index has the longest hold, so its release ends RESET.
          if (w_rst_release[NUM_DOMAINS-1]) begin
            r_state       <= S_RUN;
            r_running     <= 1'b1;
            r_cycle_count <= '0;
            r_wdog_cnt    <= '0;
          end
        end

        S_RUN: begin
          // cycle_count is left untouched on every exit so it reports the
          // value seen when the terminating condition was sampled.
          if (i_dut_error) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_status  <= ST_ERR;
          end else if (i_dut_done) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_status  <= ST_PASS;
          end else if (w_timeout) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_status  <= ST_TMO;
          end else if (w_wdog_trip) begin
            r_state        <= S_DONE;
            r_running      <= 1'b0;
            r_done         <= 1'b1;
            r_status       <= ST_TMO;
            r_wdog_expired <= 1'b1;
          end else begin
            if (!w_cycle_sat) begin
              r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            if (i_heartbeat) begin
              r_wdog_cnt <= '0;
            end else if (!w_wdog_sat) begin
              r_wdog_cnt <= r_wdog_cnt + CNT_W'(1);
            end
          end
        end

        S_DONE: begin
          if (i_start) begin
            r_state        <= S_RESET;
            r_rst_cnt      <= '0;
            r_dut_reset    <= '1;
            r_done         <= 1'b0;
            r_status       <= ST_NONE;
            r_wdog_expired <= 1'b0;
            r_cycle_count  <= '0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_dut_reset    = r_dut_reset;
  assign o_running      = r_running;
  assign o_done         = r_done;
  assign o_status       = r_status;
  assign o_wdog_expired = r_wdog_expired;
  assign o_cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_run_ctrl
//
// Directed bench for sim_run_ctrl. Instance A uses the default parameters and
// is driven from a vector table; instance B has the watchdog enabled and is
// driven by a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_sim_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        a_reset, a_start, a_done_in, a_err_in, a_hb;
  logic [1:0]  a_dut_reset;
  logic        a_running, a_done, a_wdog;
  logic [1:0]  a_status;
  logic [31:0] a_cc;

  // Instance B: watchdog enabled
  logic        b_reset, b_start, b_done_in, b_err_in, b_hb;
  logic [1:0]  b_dut_reset;
  logic        b_running, b_done, b_wdog;
  logic [1:0]  b_status;
  logic [31:0] b_cc;

  int n_pass  = 0;
  int n_total = 0;

  sim_run_ctrl #(
    .NUM_DOMAINS(2), .RST_CYCLES(2), .STAGGER(1),
    .TIMEOUT_CYCLES(10), .WDOG_CYCLES(0), .CNT_W(32)
  ) u_a (
    .i_clk(clk), .i_reset(a_reset), .i_start(a_start),
    .i_dut_done(a_done_in), .i_dut_error(a_err_in), .i_heartbeat(a_hb),
    .o_dut_reset(a_dut_reset), .o_running(a_running), .o_done(a_done),
    .o_status(a_status), .o_wdog_expired(a_wdog), .o_cycle_count(a_cc)
  );

  sim_run_ctrl #(
    .NUM_DOMAINS(2), .RST_CYCLES(2), .STAGGER(1),
    .TIMEOUT_CYCLES(100), .WDOG_CYCLES(4), .CNT_W(32)
  ) u_b (
    .i_clk(clk), .i_reset(b_reset), .i_start(b_start),
    .i_dut_done(b_done_in), .i_dut_error(b_err_in), .i_heartbeat(b_hb),
    .o_dut_reset(b_dut_reset), .o_running(b_running), .o_done(b_done),
    .o_status(b_status), .o_wdog_expired(b_wdog), .o_cycle_count(b_cc)
  );

  typedef struct {
    logic        start;
    logic        dut_done;
    logic        dut_error;
    logic [1:0]  rst;
    logic        run;
    logic        dn;
    logic [1:0]  st;
    logic        wd;
    logic [31:0] cc;
  } vec_t;

  vec_t vq[$];

  function automatic logic [63:0] pk(input logic [1:0] r, input logic run,
                                     input logic dn, input logic [1:0] st,
                                     input logic wd, input logic [31:0] cc);
    return {25'd0, r, run, dn, st, wd, cc};
  endfunction

  function automatic logic [63:0] a_outs();
    return pk(a_dut_reset, a_running, a_done, a_status, a_wdog, a_cc);
  endfunction

  function automatic logic [63:0] b_outs();
    return pk(b_dut_reset, b_running, b_done, b_status, b_wdog, b_cc);
  endfunction

  function automatic void add_vec(input logic s, input logic d, input logic e,
                                  input logic [1:0] r, input logic run,
                                  input logic dn, input logic [1:0] st,
                                  input logic [31:0] cc);
    vec_t v;
    v.start = s; v.dut_done = d; v.dut_error = e;
    v.rst = r; v.run = run; v.dn = dn; v.st = st; v.wd = 1'b0; v.cc = cc;
    vq.push_back(v);
  endfunction

  // Expected/actual layout: {dut_reset[1:0], running, done, status[1:0], wdog, cycle_count[31:0]}
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual rst=%b run=%b done=%b st=%b wd=%b cc=%0d required rst=%b run=%b done=%b st=%b wd=%b cc=%0d",
               name, act[38:37], act[36], act[35], act[34:33], act[32], act[31:0],
               exp[38:37], exp[36], exp[35], exp[34:33], exp[32], exp[31:0]);
    end else begin
      n_pass++;
    end
  endtask

  task automatic run_vecs(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      a_start   = vq[i].start;
      a_done_in = vq[i].dut_done;
      a_err_in  = vq[i].dut_error;
      @(posedge clk); #1;
      chk($sformatf("%s_vec%0d", tag, i), a_outs(),
          pk(vq[i].rst, vq[i].run, vq[i].dn, vq[i].st, vq[i].wd, vq[i].cc));
    end
    a_start = 1'b0; a_done_in = 1'b0; a_err_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: actual still running required finished");
    $fatal(1);
  end

  initial begin
    int s1_end;

    // Scenario 1: start pulse, staggered release, pass at cycle_count 5, hold 20 cycles
    add_vec(1,0,0, 2'b11,0,0,2'b00, 0);
    add_vec(0,0,0, 2'b11,0,0,2'b00, 0);
    add_vec(0,0,0, 2'b10,0,0,2'b00, 0);
    add_vec(0,0,0, 2'b00,1,0,2'b00, 0);
    for (int k = 1; k <= 5; k++) add_vec(0,0,0, 2'b00,1,0,2'b00, 32'(k));
    add_vec(0,1,0, 2'b00,0,1,2'b01, 5);
    for (int k = 0; k < 20; k++) add_vec(0,0,0, 2'b00,0,1,2'b01, 5);
    s1_end = vq.size();

    // Restart from DONE and run into the global timeout
    add_vec(1,0,0, 2'b11,0,0,2'b00, 0);
    add_vec(0,0,0, 2'b11,0,0,2'b00, 0);
    add_vec(0,0,0, 2'b10,0,0,2'b00, 0);
    add_vec(0,0,0, 2'b00,1,0,2'b00, 0);
    for (int k = 1; k <= 9; k++) add_vec(0,0,0, 2'b00,1,0,2'b00, 32'(k));
    add_vec(0,0,0, 2'b00,0,1,2'b11, 9);

    // done/error ignored outside RUN; both high in RUN gives error
    add_vec(1,1,1, 2'b11,0,0,2'b00, 0);
    add_vec(0,1,1, 2'b11,0,0,2'b00, 0);
    add_vec(0,1,1, 2'b10,0,0,2'b00, 0);
    add_vec(0,1,1, 2'b00,1,0,2'b00, 0);
    for (int k = 1; k <= 3; k++) add_vec(0,0,0, 2'b00,1,0,2'b00, 32'(k));
    add_vec(0,1,1, 2'b00,0,1,2'b10, 3);

    // start held high: back-to-back runs with a single DONE cycle between
    add_vec(1,0,0, 2'b11,0,0,2'b00, 0);
    add_vec(1,0,0, 2'b11,0,0,2'b00, 0);
    add_vec(1,0,0, 2'b10,0,0,2'b00, 0);
    add_vec(1,0,0, 2'b00,1,0,2'b00, 0);
    for (int k = 1; k <= 9; k++) add_vec(1,0,0, 2'b00,1,0,2'b00, 32'(k));
    add_vec(1,0,0, 2'b00,0,1,2'b11, 9);
    add_vec(1,0,0, 2'b11,0,0,2'b00, 0);
    add_vec(0,0,0, 2'b11,0,0,2'b00, 0);
    add_vec(0,0,0, 2'b10,0,0,2'b00, 0);
    add_vec(0,0,0, 2'b00,1,0,2'b00, 0);
    for (int k = 1; k <= 6; k++) add_vec(0,0,0, 2'b00,1,0,2'b00, 32'(k));

    a_reset = 1'b1; a_start = 1'b0; a_done_in = 1'b0; a_err_in = 1'b0; a_hb = 1'b0;
    b_reset = 1'b1; b_start = 1'b0; b_done_in = 1'b0; b_err_in = 1'b0; b_hb = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("a_in_reset", a_outs(), pk(2'b11,0,0,2'b00,0,0));
    chk("b_in_reset", b_outs(), pk(2'b11,0,0,2'b00,0,0));
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(posedge clk); #1;
    chk("a_idle_no_start", a_outs(), pk(2'b11,0,0,2'b00,0,0));

    run_vecs("tbl", 0, vq.size());

    // Instance A is now in RUN with cycle_count 6; reset between edges
    #1 a_reset = 1'b1;
    #1;
    chk("a_async_reset", a_outs(), pk(2'b11,0,0,2'b00,0,0));
    a_reset = 1'b0;
    run_vecs("rerun", 0, s1_end);

    // Instance B: watchdog kept alive, then starved
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    chk("b_start_reset", b_outs(), pk(2'b11,0,0,2'b00,0,0));
    repeat (3) @(posedge clk);
    #1;
    chk("b_run_entry", b_outs(), pk(2'b00,1,0,2'b00,0,0));
    for (int k = 0; k < 30; k++) begin
      b_hb = ((k % 3) == 2);
      @(posedge clk); #1;
      chk($sformatf("b_kick%0d", k), b_outs(), pk(2'b00,1,0,2'b00,0,32'(k + 1)));
    end
    b_hb = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk); #1;
      chk($sformatf("b_quiet%0d", j), b_outs(), pk(2'b00,1,0,2'b00,0,32'(30 + j)));
    end
    @(posedge clk); #1;
    chk("b_wdog_trip", b_outs(), pk(2'b00,0,1,2'b11,1,33));
    @(posedge clk); #1;
    chk("b_wdog_hold", b_outs(), pk(2'b00,0,1,2'b11,1,33));
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    chk("b_restart_clears", b_outs(), pk(2'b11,0,0,2'b00,0,0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
